cam_capture: RTL

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_pkg.sv | 34 +++
 rtl/cam_byte_pair.sv | 39 +++
 rtl/cam_capture.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cam_pkg
//  Brief    : Shared camera-capture types, state encoding and counter widths.
//  Revision : 1.0 - initial release
// ============================================================================
package cam_pkg;

    localparam int c_H_ACTIVE_DFLT = 640;
    localparam int c_V_ACTIVE_DFLT = 480;

    localparam int c_X_W    = 11;
    localparam int c_Y_W    = 10;
    localparam int c_FCNT_W = 16;

    typedef logic [1:0] cam_state_t;

    localparam cam_state_t c_ST_WAIT_VS    = 2'd0;
    localparam cam_state_t c_ST_WAIT_FRAME = 2'd1;
    localparam cam_state_t c_ST_ACTIVE     = 2'd2;
    localparam cam_state_t c_ST_SKIP       = 2'd3;

    // Saturating increments keep over-long lines/frames from wrapping back
    // into a value that would look like a legal length.
    function automatic logic [c_X_W-1:0] cam_sat_inc_x(input logic [c_X_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [c_Y_W-1:0] cam_sat_inc_y(input logic [c_Y_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_byte_pair.sv
`default_nettype none
// ============================================================================
//  Module   : cam_byte_pair
//  Brief    : Tracks the byte phase within a line and assembles 16-bit pixels.
//  Revision : 1.0 - initial release
// ============================================================================
module cam_byte_pair (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_href,
    input  logic [7:0]  i_data,
    output logic        o_pair_done,
    output logic [15:0] o_pair_data,
    output logic        o_phase
);

    logic       r_phase;
    logic [7:0] r_hold;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase <= 1'b0;
            r_hold  <= 8'h00;
        end else if (!i_href) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_hold <= i_data;
            end
        end
    end

    assign o_pair_done = i_href & r_phase;
    assign o_pair_data = {r_hold, i_data};
    assign o_phase     = r_phase;

endmodule
`default_nettype wire

// File: rtl/cam_capture.sv
`default_nettype none
// ============================================================================
//  Module   : cam_capture
//  Brief    : DVP-style RGB565 camera capture with frame FSM and error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE_DFLT,
    parameter int V_ACTIVE = c_V_ACTIVE_DFLT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                capture_en,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic [7:0]          cam_data,
    input  logic                err_clr,
    output logic                pix_valid,
    output logic [15:0]         pix_data,
    output logic                pix_sof,
    output logic                pix_eol,
    output logic [c_X_W-1:0]    pix_x,
    output logic [c_Y_W-1:0]    pix_y,
    output logic [c_FCNT_W-1:0] frame_cnt,
    output logic                err_line,
    output logic                err_frame
);

    localparam logic [c_X_W-1:0] c_H      = c_X_W'(H_ACTIVE);
    localparam logic [c_X_W-1:0] c_H_LAST = c_X_W'(H_ACTIVE - 1);
    localparam logic [c_Y_W-1:0] c_V      = c_Y_W'(V_ACTIVE);

    logic       r_vs;
    logic       r_vs_d;
    logic       r_href;
    logic       r_href_d;
    logic [7:0] r_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vs     <= 1'b0;
            r_vs_d   <= 1'b0;
            r_href   <= 1'b0;
            r_href_d <= 1'b0;
            r_data   <= 8'h00;
        end else begin
            r_vs     <= cam_vsync;
            r_vs_d   <= r_vs;
            r_href   <= cam_href;
            r_href_d <= r_href;
            r_data   <= cam_data;
        end
    end

    logic        w_pair_done;
    logic [15:0] w_pair_data;
    logic        w_phase;

    cam_byte_pair u_byte_pair (
        .clk         (clk),
        .rstn        (rstn),
        .i_href      (r_href),
        .i_data      (r_data),
        .o_pair_done (w_pair_done),
        .o_pair_data (w_pair_data),
        .o_phase     (w_phase)
    );

    cam_state_t       r_state;
    logic [c_X_W-1:0] r_x;
    logic [c_Y_W-1:0] r_y;

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_href_fall;
    logic w_active;
    logic w_pix_ok;
    logic w_abandon;
    logic w_frame_end;
    logic w_line_err_set;
    logic w_frame_err_set;

    assign w_vs_rise   = r_vs & ~r_vs_d;
    assign w_vs_fall   = ~r_vs & r_vs_d;
    assign w_href_fall = ~r_href & r_href_d;
    assign w_active    = (r_state == c_ST_ACTIVE);

    // Bytes past the active window still pair up but never produce a pixel.
    assign w_pix_ok    = w_active & w_pair_done & (r_x < c_H) & (r_y < c_V);

    assign w_abandon       = w_active & w_vs_rise & r_href;
    assign w_frame_end     = w_active & w_vs_rise;
    assign w_line_err_set  = (w_active & w_href_fall & ((r_x != c_H) | w_phase)) | w_abandon;
    assign w_frame_err_set = w_frame_end & ((r_y != c_V) | w_abandon);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= c_ST_WAIT_VS;
            r_x       <= '0;
            r_y       <= '0;
            pix_valid <= 1'b0;
            pix_data  <= 16'h0000;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            frame_cnt <= '0;
            err_line  <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            case (r_state)
                c_ST_WAIT_VS: begin
                    if (w_vs_rise) r_state <= c_ST_WAIT_FRAME;
                end
                c_ST_WAIT_FRAME: begin
                    if (w_vs_fall) r_state <= capture_en ? c_ST_ACTIVE : c_ST_SKIP;
                end
                c_ST_ACTIVE, c_ST_SKIP: begin
                    if (w_vs_rise) r_state <= c_ST_WAIT_FRAME;
                end
                default: r_state <= c_ST_WAIT_VS;
            endcase

            // Position counters are held at zero while waiting for the frame to open.
            if (r_state == c_ST_WAIT_FRAME) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_active) begin
                if (w_pair_done) begin
                    r_x <= cam_sat_inc_x(r_x);
                end
                if (w_href_fall) begin
                    r_x <= '0;
                    if (r_x != '0) r_y <= cam_sat_inc_y(r_y);
                end
            end

            pix_valid <= w_pix_ok;
            pix_sof   <= w_pix_ok & (r_x == '0) & (r_y == '0);
            pix_eol   <= w_pix_ok & (r_x == c_H_LAST);
            if (w_pix_ok) begin
                pix_data <= w_pair_data;
                pix_x    <= r_x;
                pix_y    <= r_y;
            end

            if (w_frame_end) frame_cnt <= frame_cnt + 1'b1;

            // A new error in the same cycle as a clear request keeps the flag set.
            err_line  <= (err_line  & ~err_clr) | w_line_err_set;
            err_frame <= (err_frame & ~err_clr) | w_frame_err_set;
        end
    end

endmodule
`default_nettype wire
